// File: rtl/rom_fetch.sv
// Burst read initiator for the uncore ROM: walks word addresses on the registered
// ROM read port and re-times the returned words into a back-pressurable stream.
module rom_fetch #(
    parameter int unsigned AD_LEN       = 32,
    parameter int unsigned BUS_WIDTH    = 32,
    parameter int unsigned ROM_MAX_ADDR = 32'h2000,
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AD_LEN-1:0]    req_addr_i,
    input  logic [CNT_W-1:0]     req_count_i,
    output logic [AD_LEN-1:0]    rom_ad_o,
    input  logic [BUS_WIDTH-1:0] rom_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [BUS_WIDTH-1:0] out_data_o,
    output logic [AD_LEN-1:0]    out_addr_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int unsigned EW = AD_LEN + CNT_W + 2;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = OW + 1;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state_q;
    logic [AD_LEN-1:0]     cur_q;
    logic [CNT_W-1:0]      rem_q;
    logic [AD_LEN-1:0]     rom_ad_q;
    logic                  err_q;
    logic                  t1_vld_q, t2_vld_q;
    logic [AD_LEN-1:0]     t1_addr_q, t2_addr_q;
    logic                  t1_last_q, t2_last_q;

    logic [BUS_WIDTH-1:0]  fd_q [FIFO_DEPTH];
    logic [AD_LEN-1:0]     fa_q [FIFO_DEPTH];
    logic                  fl_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]         occ_q;

    logic [EW-1:0]         end_addr;
    logic                  accept, req_bad, start, credit_ok, issue_more, issue;
    logic                  iss_last, push, pop;
    logic [AD_LEN-1:0]     iss_addr;
    logic [1:0]            inflight;

    always_comb begin
        accept     = req_valid_i & req_ready_o;
        end_addr   = EW'(req_addr_i) + (EW'(req_count_i) << 2);
        req_bad    = (req_addr_i[1:0] != 2'b00) | (req_count_i == '0)
                   | (end_addr > EW'(ROM_MAX_ADDR));
        start      = accept & ~req_bad;
        inflight   = {1'b0, t1_vld_q} + {1'b0, t2_vld_q};
        credit_ok  = (SW'(occ_q) + SW'(inflight)) < SW'(FIFO_DEPTH);
        issue_more = (state_q == FETCH) & (rem_q != '0) & credit_ok;
        // The first word goes out in the accept cycle itself so the ROM address
        // is already valid one cycle after the handshake; the FIFO is empty then.
        issue      = start | issue_more;
        iss_addr   = start ? req_addr_i : cur_q;
        iss_last   = start ? (req_count_i == CNT_W'(1)) : (rem_q == CNT_W'(1));
        push       = t2_vld_q;
        pop        = out_valid_o & out_ready_i;
    end

    assign req_ready_o = (state_q == IDLE) & ~reset_i;
    assign busy_o      = (state_q == FETCH);
    assign err_o       = err_q;
    assign rom_ad_o    = rom_ad_q;
    assign out_valid_o = (occ_q != '0);
    assign out_data_o  = fd_q[rd_ptr_q];
    assign out_addr_o  = fa_q[rd_ptr_q];
    assign out_last_o  = out_valid_o & fl_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            rem_q     <= '0;
            rom_ad_q  <= '0;
            err_q     <= 1'b0;
            t1_vld_q  <= 1'b0;
            t2_vld_q  <= 1'b0;
            t1_addr_q <= '0;
            t2_addr_q <= '0;
            t1_last_q <= 1'b0;
            t2_last_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            err_q     <= accept & req_bad;
            t2_vld_q  <= t1_vld_q;
            t2_addr_q <= t1_addr_q;
            t2_last_q <= t1_last_q;
            t1_vld_q  <= issue;
            if (issue) begin
                t1_addr_q <= iss_addr;
                t1_last_q <= iss_last;
                rom_ad_q  <= iss_addr;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q <= FETCH;
                    cur_q   <= req_addr_i + AD_LEN'(4);
                    rem_q   <= req_count_i - CNT_W'(1);
                end
                FETCH: begin
                    if (issue_more) begin
                        cur_q <= cur_q + AD_LEN'(4);
                        rem_q <= rem_q - CNT_W'(1);
                    end
                    if (pop && out_last_o) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end

    // Payload storage needs no reset: occupancy and pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fd_q[wr_ptr_q] <= rom_data_i;
            fa_q[wr_ptr_q] <= t2_addr_q;
            fl_q[wr_ptr_q] <= t2_last_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!(push && !pop && occ_q == OW'(FIFO_DEPTH)));
    end
endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: registered ROM model preloaded with A000_0000+i and a
// queue of expected beats computed from each request's address and count.
module tb_rom_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [11:0] req_count;
    logic [31:0] rom_ad;
    logic [31:0] rom_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_last;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [31:0] d; logic [31:0] a; logic l; } beat_t;
    beat_t exp_q[$];
    logic [31:0] rom [0:2047];

    rom_fetch dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_count_i(req_count),
        .rom_ad_o(rom_ad), .rom_data_i(rom_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_addr_o(out_addr), .out_last_o(out_last),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_ad[12:2]];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic add_exp(input logic [31:0] addr, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            beat_t b;
            b.d = 32'hA000_0000 + (addr >> 2) + i;
            b.a = addr + 4 * i;
            b.l = (i == cnt - 1);
            exp_q.push_back(b);
        end
    endtask

    // Present a request for exactly one cycle; returns in cycle 1 after the handshake.
    task automatic hs(input logic [31:0] a, input logic [11:0] c);
        req_addr = a; req_count = c; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready
    task automatic drain(input int mode, input int start_cyc, output int last_cyc);
        int cyc = start_cyc;
        int ph = 0;
        beat_t b;
        last_cyc = -1;
        while (exp_q.size() > 0 && cyc < start_cyc + 2000) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (ph % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            if (out_valid && out_ready) begin
                b = exp_q.pop_front();
                checks++;
                if (out_data !== b.d || out_addr !== b.a || out_last !== b.l) begin
                    failures++;
                    $display("FAIL beat: got d=%h a=%h l=%b, want d=%h a=%h l=%b",
                             out_data, out_addr, out_last, b.d, b.a, b.l);
                end
                if (b.l) last_cyc = cyc;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_count = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rom_ad !== 32'h0 || out_valid !== 1'b0 || out_last !== 1'b0
            || busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b ad=%h v=%b last=%b busy=%b err=%b, want 0 0 0 0 0 0",
                     req_ready, rom_ad, out_valid, out_last, busy, err);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
    endtask

    task automatic burst_latency(input logic [31:0] addr, input int cnt);
        int lc;
        out_ready = 1'b1;
        hs(addr, 12'(cnt));
        add_exp(addr, cnt);
        checks++;
        if (rom_ad !== addr || out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cycle1: ad=%h v=%b busy=%b, want ad=%h v=0 busy=1", rom_ad, out_valid, busy, addr);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL cycle2_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL first_valid_cycle3: got %b want 1", out_valid);
        end
        drain(0, 3, lc);
        checks++;
        if (lc !== cnt + 2) begin
            failures++; $display("FAIL last_pop_cycle: got %0d want %0d", lc, cnt + 2);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_burst: busy=%b v=%b rdy=%b, want 0 0 1", busy, out_valid, req_ready);
        end
    endtask

    task automatic test_basic;
        burst_latency(32'h10, 4);
    endtask

    task automatic test_backpressure;
        int lc;
        hs(32'h10, 12'd4);
        add_exp(32'h10, 4);
        drain(1, 1, lc);
        out_ready = 1'b0;
        hs(32'h40, 12'd10);
        repeat (11) @(negedge clk);
        checks++;
        if (rom_ad !== 32'h4C || out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall: ad=%h v=%b busy=%b, want ad=0000004c v=1 busy=1", rom_ad, out_valid, busy);
        end
        add_exp(32'h40, 10);
        drain(2, 12, lc);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL idle_after_bp: busy=%b v=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reject;
        logic [31:0] ra [5] = '{32'h2, 32'h1FFC, 32'h0, 32'h0, 32'hFFFF_FFFC};
        logic [11:0] rc [5] = '{12'd1, 12'd2, 12'd0, 12'd4095, 12'd1};
        for (int k = 0; k < 5; k++) begin
            logic [31:0] pre_ad;
            logic bad;
            pre_ad = rom_ad;
            hs(ra[k], rc[k]);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reject%0d_err: err=%b busy=%b, want 1 0", k, err, busy);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin
                failures++; $display("FAIL reject%0d_pulse: err=%b want 0", k, err);
            end
            bad = 1'b0;
            repeat (4) begin
                if (out_valid !== 1'b0 || busy !== 1'b0 || rom_ad !== pre_ad) bad = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL reject%0d_quiet: v=%b busy=%b ad=%h, want 0 0 %h", k, out_valid, busy, rom_ad, pre_ad);
            end
        end
        burst_latency(32'h1FFC, 1);
    endtask

    task automatic test_midburst_reset;
        out_ready = 1'b0;
        hs(32'h100, 12'd16);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rom_ad !== 32'h0 || out_valid !== 1'b0 || out_last !== 1'b0
            || busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midreset: rdy=%b ad=%h v=%b last=%b busy=%b err=%b, want all 0",
                     req_ready, rom_ad, out_valid, out_last, busy, err);
        end
        reset = 1'b0;
        @(negedge clk);
        burst_latency(32'h400, 5);
    endtask

    task automatic test_back_to_back;
        int cyc = 1;
        int hs2 = -1;
        int last1 = -1;
        beat_t b;
        out_ready = 1'b1;
        req_addr = 32'h200; req_count = 12'd1; req_valid = 1'b1;
        @(negedge clk);
        req_addr = 32'h300; req_count = 12'd3;
        add_exp(32'h200, 1);
        add_exp(32'h300, 3);
        while (exp_q.size() > 0 && cyc < 100) begin
            if (out_valid) begin
                b = exp_q.pop_front();
                checks++;
                if (out_data !== b.d || out_addr !== b.a || out_last !== b.l) begin
                    failures++;
                    $display("FAIL b2b_beat: got d=%h a=%h l=%b, want d=%h a=%h l=%b",
                             out_data, out_addr, out_last, b.d, b.a, b.l);
                end
                if (b.l && last1 < 0) last1 = cyc;
            end
            if (req_valid && req_ready) hs2 = cyc;
            @(negedge clk); cyc++;
            if (hs2 >= 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_timeout: %0d beats outstanding", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (last1 != 3 || hs2 != 4) begin
            failures++; $display("FAIL b2b_accept: last_pop=%0d accept=%0d, want 3 and 4", last1, hs2);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_extra: v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_random;
        int lc;
        for (int k = 0; k < 8; k++) begin
            int cnt;
            logic [31:0] a;
            cnt = $urandom_range(1, 24);
            a = 32'($urandom_range(0, 2048 - cnt)) * 4;
            hs(a, 12'(cnt));
            add_exp(a, cnt);
            drain(2, 1, lc);
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d_idle: busy=%b v=%b rdy=%b, want 0 0 1", k, busy, out_valid, req_ready);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 32'hA000_0000 + i;
        @(negedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_reject;
        test_midburst_reset;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
